campo_asteroides: RTL
=====================

// Module: campo_asteroides
// PURPOSE
//  Parametrised multi-asteroid game datapath with its own sweep controller.
//  Holds up to N_AST asteroids, spawns them through a ready/valid handshake and advances all of them on each tick.
//  Resolves shots and ship collisions, and keeps the life counter.
//  Sits between the game-control FSM (tick/restart) and the display/debug outputs.
// PARAMETERS
//  N_AST      4  number of asteroid slots (2..16)
//  COOR_W     4  coordinate width, x and y
//  VIDAS_W    4  life-counter width
//  VIDAS_INIT 3  lives loaded at reset/restart
//  SHIP_X     3  ship column (fixed position unless SHIP_MOVE_EN)
//  SHIP_Y     0  ship row
// PORTS
//  clock        in   1          system clock, rising edge
//  reset_n      in   1          async active-low reset
//  restart      in   1          sync: reload lives, free all slots, state IDLE
//  jogada       in   6          [5]up [4]down [3]right [2]left [1]special [0]shot
//  tick         in   1          1-cycle pulse, starts a sweep; ignored unless IDLE and lives>0
//  spawn_valid  in   1          spawn request
//  spawn_ready  out  1          IDLE & free slot & lives>0 & !restart
//  spawn_x      in   COOR_W     new asteroid x
//  spawn_y      in   COOR_W     new asteroid y
//  spawn_fast   in   1          1: step 2 per tick, 0: step 1
//  busy         out  1          sweep in progress
//  done         out  1          1-cycle pulse at end of sweep
//  colisao      out  1          1-cycle pulse with done if >=1 collision in the sweep
//  acertou      out  1          1-cycle pulse with done if the shot destroyed an asteroid
//  vidas        out  1          num_vidas != 0
//  num_vidas    out  VIDAS_W    current lives
//  ativos       out  N_AST      slot-occupied bitmap
//  db_nave_x    out  COOR_W     current ship x
// BEHAVIOUR
//  Reset values: all slots free, num_vidas=VIDAS_INIT, state IDLE, every pulse output 0.
//  restart has priority over every other input; its effect equals reset but is synchronous.
//  Spawn:
//   - Handshake on spawn_valid & spawn_ready.
//   - Writes the lowest-index free slot; ativos bit set next cycle.
//  States: IDLE -> SWEEP (slot i = 0..N_AST-1, one slot per cycle) -> DONE -> IDLE.
//  Sweep entry: tick in IDLE latches jogada (shot_pend = jogada[0]) and sets i=0.
//   - tick and a spawn handshake in the same cycle: the spawn is written first, so the new asteroid moves in this sweep.
//  Per slot i (only if occupied), in priority order:
//   1. shot_pend & x==ship_x: slot freed, hit flag set, shot_pend cleared (one kill per shot, lowest index wins).
//   2. y < step: slot freed (escaped off-field, no penalty).
//   3. Otherwise y -= step, with step = fast ? 2 : 1.
//      If the new (x,y) equals the ship: slot freed, collision flag set, lives decremented.
//  Lives saturate at 0. More than one collision in a sweep decrements once per collision, never below 0.
//  DONE lasts 1 cycle: asserts done, plus colisao/acertou from the flags; flags then cleared.
//   - Latency: done occurs N_AST+1 cycles after the tick cycle.
//  tick while busy: ignored. Lives 0: ticks ignored, spawn_ready=0, until restart.
//  Asynchronous reset during a sweep aborts it; no done pulse is issued.
//  All coordinate arithmetic is in COOR_W bits; x is never modified by a sweep.
// CONFIGURATION
//  CAMPO_SHIP_MOVE_EN defined:
//   - Ship x is a register reset to SHIP_X, updated once per sweep entry.
//   - jogada[3] increments x, jogada[2] decrements x. Both set or neither: no change.
//   - x saturates at 0 and at 2^COOR_W-1. The new x is used for that sweep.
//  Macro undefined: ship x is the constant SHIP_X; jogada[5:1] are unused.
// STRUCTURE
//  Package campo_pkg:
//   - state encoding (IDLE/SWEEP/DONE)
//   - step constants STEP_SLOW=1, STEP_FAST=2
//   - jogada bit-index constants
//  Sub-module asteroide_slot: holds x, y, fast and valid for one slot, with load/free/update controls.
//   - Instantiated N_AST times.
//   - Move, hit and collision resolution is done by a single shared unit at index i.
// TESTING
//  1. Reset: num_vidas=3, vidas=1, ativos=0, spawn_ready=1; no pulses.
//  2. Spawn (3,2,slow), 2 ticks: y 2->1->0, collision on the 2nd done; num_vidas=2; ativos=0.
//  3. Spawn (3,5) and (1,5), tick with jogada=000001: slot0 freed, acertou=1; slot1 y=4.
//  4. Spawn (2,1,fast), tick: escapes, ativos=0, colisao=0, lives unchanged.
//  5. Fill all 4 slots: spawn_ready=0. 3 collisions to 0 lives: vidas=0, ticks ignored; restart -> lives 3.
//  6. CAMPO_SHIP_MOVE_EN: 16 ticks with right -> db_nave_x saturates at 15; left+right together -> unchanged.

Source files
------------

// File: rtl/campo_pkg.sv
// Shared constants for the asteroid-field datapath: sweep states, step sizes and jogada bit positions.
package campo_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int STEP_SLOW = 1;
    localparam int STEP_FAST = 2;

    localparam int JOG_UP      = 5;
    localparam int JOG_DOWN    = 4;
    localparam int JOG_RIGHT   = 3;
    localparam int JOG_LEFT    = 2;
    localparam int JOG_SPECIAL = 1;
    localparam int JOG_SHOT    = 0;

endpackage

// File: rtl/asteroide_slot.sv
// One asteroid slot: position, speed and occupancy. Restart beats load, load beats free, free beats update.
module asteroide_slot import campo_pkg::*; #(
    parameter int COOR_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              restart,
    input  logic              load,
    input  logic [COOR_W-1:0] load_x,
    input  logic [COOR_W-1:0] load_y,
    input  logic              load_fast,
    input  logic              free,
    input  logic              update,
    input  logic [COOR_W-1:0] new_y,
    output logic [COOR_W-1:0] x,
    output logic [COOR_W-1:0] y,
    output logic              fast,
    output logic              valid
);

    logic [COOR_W-1:0] x_reg;
    logic [COOR_W-1:0] y_reg;
    logic              fast_reg;
    logic              valid_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_reg     <= '0;
            y_reg     <= '0;
            fast_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else if (restart) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            x_reg     <= load_x;
            y_reg     <= load_y;
            fast_reg  <= load_fast;
            valid_reg <= 1'b1;
        end else if (free) begin
            valid_reg <= 1'b0;
        end else if (update) begin
            y_reg <= new_y;
        end
    end

    assign x     = x_reg;
    assign y     = y_reg;
    assign fast  = fast_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/campo_asteroides.sv
// Multi-asteroid field: spawn handshake, per-tick sweep over all slots, shot/collision resolution, lives.
// Optional CAMPO_SHIP_MOVE_EN makes the ship column a register steered by jogada right/left.
module campo_asteroides import campo_pkg::*; #(
    parameter int N_AST      = 4,
    parameter int COOR_W     = 4,
    parameter int VIDAS_W    = 4,
    parameter int VIDAS_INIT = 3,
    parameter int SHIP_X     = 3,
    parameter int SHIP_Y     = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               restart,
    input  logic [5:0]         jogada,
    input  logic               tick,
    input  logic               spawn_valid,
    output logic               spawn_ready,
    input  logic [COOR_W-1:0]  spawn_x,
    input  logic [COOR_W-1:0]  spawn_y,
    input  logic               spawn_fast,
    output logic               busy,
    output logic               done,
    output logic               colisao,
    output logic               acertou,
    output logic               vidas,
    output logic [VIDAS_W-1:0] num_vidas,
    output logic [N_AST-1:0]   ativos,
    output logic [COOR_W-1:0]  db_nave_x
);

    localparam int IDX_W = (N_AST > 1) ? $clog2(N_AST) : 1;

    logic [1:0]         state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               shot_pend_reg;
    logic               hit_flag_reg;
    logic               col_flag_reg;
    logic [VIDAS_W-1:0] vidas_reg;

    logic [COOR_W-1:0]  slot_x [N_AST];
    logic [COOR_W-1:0]  slot_y [N_AST];
    logic [N_AST-1:0]   slot_fast;
    logic [N_AST-1:0]   slot_valid;
    logic [N_AST-1:0]   slot_load;
    logic [N_AST-1:0]   slot_free;
    logic [N_AST-1:0]   slot_update;

    logic [IDX_W-1:0]   free_idx;
    logic [COOR_W-1:0]  ship_x;
    logic [COOR_W-1:0]  cur_x;
    logic [COOR_W-1:0]  cur_y;
    logic [COOR_W-1:0]  step;
    logic [COOR_W-1:0]  new_y;
    logic               kill_shot;
    logic               kill_col;
    logic               spawn_fire;
    logic               tick_fire;
    logic               is_idle;

    assign is_idle     = (state_reg == ST_IDLE);
    assign spawn_ready = is_idle && !(&slot_valid) && (vidas_reg != '0) && !restart;
    assign spawn_fire  = spawn_valid && spawn_ready;
    assign tick_fire   = tick && is_idle && (vidas_reg != '0) && !restart;

    always_comb begin
        free_idx = '0;
        for (int k = N_AST - 1; k >= 0; k--) begin
            if (!slot_valid[k]) free_idx = IDX_W'(k);
        end
    end

    for (genvar gi = 0; gi < N_AST; gi++) begin : g_slot
        asteroide_slot #(.COOR_W(COOR_W)) u_slot (
            .clock     (clock),
            .reset_n   (reset_n),
            .restart   (restart),
            .load      (slot_load[gi]),
            .load_x    (spawn_x),
            .load_y    (spawn_y),
            .load_fast (spawn_fast),
            .free      (slot_free[gi]),
            .update    (slot_update[gi]),
            .new_y     (new_y),
            .x         (slot_x[gi]),
            .y         (slot_y[gi]),
            .fast      (slot_fast[gi]),
            .valid     (slot_valid[gi])
        );
    end

`ifdef CAMPO_SHIP_MOVE_EN
    logic [COOR_W-1:0] nave_x_reg;
    logic              unused_jog;

    // Ship moves on sweep entry, so the sweep it starts already sees the new column.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            nave_x_reg <= COOR_W'(SHIP_X);
        end else if (restart) begin
            nave_x_reg <= COOR_W'(SHIP_X);
        end else if (tick_fire) begin
            if (jogada[JOG_RIGHT] && !jogada[JOG_LEFT] && (nave_x_reg != '1))
                nave_x_reg <= nave_x_reg + COOR_W'(1);
            else if (jogada[JOG_LEFT] && !jogada[JOG_RIGHT] && (nave_x_reg != '0))
                nave_x_reg <= nave_x_reg - COOR_W'(1);
        end
    end

    assign ship_x     = nave_x_reg;
    assign unused_jog = ^{jogada[JOG_UP], jogada[JOG_DOWN], jogada[JOG_SPECIAL]};
`else
    logic unused_jog;

    assign ship_x     = COOR_W'(SHIP_X);
    assign unused_jog = ^jogada[JOG_UP:JOG_SPECIAL];
`endif

    assign cur_x = slot_x[idx_reg];
    assign cur_y = slot_y[idx_reg];

    always_comb begin
        slot_load   = '0;
        slot_free   = '0;
        slot_update = '0;
        kill_shot   = 1'b0;
        kill_col    = 1'b0;
        step        = slot_fast[idx_reg] ? COOR_W'(STEP_FAST) : COOR_W'(STEP_SLOW);
        new_y       = cur_y - step;
        if (spawn_fire) slot_load[free_idx] = 1'b1;
        if ((state_reg == ST_SWEEP) && slot_valid[idx_reg]) begin
            if (shot_pend_reg && (cur_x == ship_x)) begin
                kill_shot          = 1'b1;
                slot_free[idx_reg] = 1'b1;
            end else if (cur_y < step) begin
                slot_free[idx_reg] = 1'b1;
            end else if ((cur_x == ship_x) && (new_y == COOR_W'(SHIP_Y))) begin
                kill_col           = 1'b1;
                slot_free[idx_reg] = 1'b1;
            end else begin
                slot_update[idx_reg] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            shot_pend_reg <= 1'b0;
            hit_flag_reg  <= 1'b0;
            col_flag_reg  <= 1'b0;
            vidas_reg     <= VIDAS_W'(VIDAS_INIT);
        end else if (restart) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            shot_pend_reg <= 1'b0;
            hit_flag_reg  <= 1'b0;
            col_flag_reg  <= 1'b0;
            vidas_reg     <= VIDAS_W'(VIDAS_INIT);
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (tick_fire) begin
                        state_reg     <= ST_SWEEP;
                        idx_reg       <= '0;
                        shot_pend_reg <= jogada[JOG_SHOT];
                        hit_flag_reg  <= 1'b0;
                        col_flag_reg  <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (kill_shot) begin
                        hit_flag_reg  <= 1'b1;
                        shot_pend_reg <= 1'b0;
                    end
                    // Each collision costs one life; the counter stops at zero.
                    if (kill_col) begin
                        col_flag_reg <= 1'b1;
                        if (vidas_reg != '0) vidas_reg <= vidas_reg - VIDAS_W'(1);
                    end
                    if (idx_reg == IDX_W'(N_AST - 1)) state_reg <= ST_DONE;
                    else idx_reg <= idx_reg + IDX_W'(1);
                end
                ST_DONE: begin
                    state_reg     <= ST_IDLE;
                    shot_pend_reg <= 1'b0;
                    hit_flag_reg  <= 1'b0;
                    col_flag_reg  <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy      = !is_idle;
    assign done      = (state_reg == ST_DONE);
    assign colisao   = done && col_flag_reg;
    assign acertou   = done && hit_flag_reg;
    assign vidas     = (vidas_reg != '0);
    assign num_vidas = vidas_reg;
    assign ativos    = slot_valid;
    assign db_nave_x = ship_x;

endmodule
